apb_cmd_bridge: RTL



---
 rtl/apb_cmd_bridge.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/apb_cmd_bridge.sv
// apb_cmd_bridge: converts a valid/ready command channel into one APB requester
// transfer per command and returns the completion on a valid/ready response channel.
// At most one transfer is in flight; every output is driven from a register.
// Optional build macro APB_TIMEOUT_EN adds an ACCESS-phase watchdog that aborts a
// transfer after TIMEOUT_CYCLES cycles with pready low. Without it, ACCESS waits
// for pready indefinitely and rsp_timeout is tied low.
`timescale 1ns/1ps

module apb_cmd_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  timeout_hit;

  logic                  cmd_ready_nxt;
  logic                  psel_nxt;
  logic                  penable_nxt;
  logic                  rsp_valid_nxt;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic                  pwrite_nxt;
  logic [DATA_WIDTH-1:0] pwdata_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
  logic                  rsp_err_nxt;

  // A watchdog limit of zero would abort before the completer could ever answer.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_cmd_bridge: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef APB_TIMEOUT_EN
  localparam int                CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             rsp_timeout_nxt;

  // Count ACCESS cycles with pready low; held at zero elsewhere so each ACCESS starts fresh.
  always_ff @(posedge pclk) begin
    if (preset || (state != ACCESS) || pready) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // The current cycle is the TIMEOUT_CYCLES-th wait cycle; pready in this cycle still wins.
  assign timeout_hit = (state == ACCESS) && !pready && (wait_cnt == LIMIT);
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // State and output registers; reset returns to IDLE and discards any pending response.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      rsp_valid   <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cmd_ready   <= cmd_ready_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      rsp_valid   <= rsp_valid_nxt;
      paddr       <= paddr_nxt;
      pwrite      <= pwrite_nxt;
      pwdata      <= pwdata_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
`ifdef APB_TIMEOUT_EN
      rsp_timeout <= rsp_timeout_nxt;
`endif
    end
  end

  // Next-state: one command becomes SETUP -> ACCESS -> RESP, then back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid && cmd_ready) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next output values, decoded from the next state so the registered outputs line up with it.
  always_comb begin
    cmd_ready_nxt = (state_nxt == IDLE);
    psel_nxt      = (state_nxt == SETUP) || (state_nxt == ACCESS);
    penable_nxt   = (state_nxt == ACCESS);
    rsp_valid_nxt = (state_nxt == RESP);
    paddr_nxt     = paddr;
    pwrite_nxt    = pwrite;
    pwdata_nxt    = pwdata;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
`ifdef APB_TIMEOUT_EN
    rsp_timeout_nxt = rsp_timeout;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          paddr_nxt  = cmd_addr;
          pwrite_nxt = cmd_write;
          pwdata_nxt = cmd_write ? cmd_wdata : '0;
        end
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_nxt = pwrite ? '0 : prdata;
          rsp_err_nxt   = pslverr;
`ifdef APB_TIMEOUT_EN
          rsp_timeout_nxt = 1'b0;
        end else if (timeout_hit) begin
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b0;
`ifdef APB_TIMEOUT_EN
          rsp_timeout_nxt = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule
